gate_test_sequencer: RTL and testbench
======================================

Name: gate_test_sequencer

Overview:
- Self-test controller for any 2-input combinational logic gate (XNOR, XOR, AND, …).
- On a start pulse, it drives the gate inputs through all four {a,b} combinations and holds each for a programmable dwell time.
- It samples the gate output at the end of each dwell, then compares the captured 4-bit truth table against an expected pattern.
- Sits beside the gate on the FPGA top level as the gate's input driver and checker; reports done/pass/mismatch to LEDs or a bench.

Parameters:
- DWELL_CYCLES, 4, clock cycles each input combination is held before sampling (legal range 1..255).
- EXPECTED, 4'b1001, expected truth table; bit index = {a,b} (default = XNOR).
- CNT_W, 8, width of the dwell counter; must hold DWELL_CYCLES-1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level sampled each cycle; accepted only in IDLE.
- gate_out  input  1  output of the gate under test.
- gate_a  output  1  drives gate input a.
- gate_b  output  1  drives gate input b.
- busy  output  1  high while a sweep or report is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  1 when result == EXPECTED; held until next accepted start.
- result  output  4  captured gate_out per combination, bit {a,b}.
- mismatch  output  4  result XOR EXPECTED; held until next accepted start.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- All outputs are registered.
- Reset values: gate_a=0, gate_b=0, busy=0, done=0, pass=0, result=0, mismatch=0, state=IDLE, combo=0, dwell counter=0.
- FSM states:
  - IDLE: gate_a/gate_b=0. If start=1, go to APPLY with combo=0 and dwell=0, and clear result, mismatch and pass.
  - APPLY: {gate_a,gate_b}=combo; busy=1; dwell increments each cycle.
    - On the cycle dwell==DWELL_CYCLES-1, capture result[combo] <= gate_out.
    - If combo==3, go to REPORT; else increment combo and reset dwell to 0.
  - REPORT: one cycle only.
    - done=1, busy=1, gate_a/gate_b=0.
    - pass and mismatch are computed from the complete 4-bit result, including the final sample.
    - Next state is IDLE.
- Latency: start accepted at cycle T → APPLY from T+1 → 4*DWELL_CYCLES APPLY cycles → done high at T+1+4*DWELL_CYCLES.
- busy drops the following cycle.
- The gate is combinational, so gate_out is valid in the same cycle gate_a/gate_b change. Sampling on the last dwell cycle is therefore correct even with DWELL_CYCLES=1.
- start while busy (APPLY or REPORT) is ignored; there is no queueing.
- start held high continuously: a new sweep begins on the first IDLE cycle after REPORT, which gives back-to-back sweeps with 1 IDLE cycle between them.
- rst mid-sweep: everything returns to reset values on that edge; no done pulse; partial result is discarded.
- rst has priority over start in the same cycle.
- combo is a 2-bit counter: 0,1,2,3, no wrap within a sweep.

Decomposition:
- Package gate_test_pkg holds:
  - state encoding constants S_IDLE, S_APPLY, S_REPORT.
  - truth-table constants TT_XNOR=4'b1001, TT_XOR=4'b0110, TT_AND=4'b1000, TT_OR=4'b1110.
  - COMBO_W=2.
- One natural sub-module, dwell_timer: a CNT_W-bit counter with clear/enable and a terminal-count flag at DWELL_CYCLES-1.
- FSM, combo counter and capture logic stay in gate_test_sequencer.

Test Plan:
- XNOR gate, DWELL_CYCLES=4, start pulse at cycle 5 → busy=1 from cycle 6; (a,b)=00,01,10,11 for 4 cycles each; done pulse at cycle 22; result=1001, mismatch=0000, pass=1.
- XOR gate in place, EXPECTED=1001 → result=0110, mismatch=1111, pass=0, done pulse at the same cycle.
- gate_out tied to 1 → result=1111, mismatch=0110, pass=0.
- start reasserted at cycles 10 and 21 during the sweep → ignored; exactly one done pulse at cycle 22; start held high afterwards → next sweep's APPLY begins at cycle 24.
- rst pulsed at cycle 15 (combo=2) → cycle 16: all outputs 0, state IDLE, no done; new start at cycle 20 → sweep restarts at combo 00, done at cycle 37.
- DWELL_CYCLES=1, XNOR gate, start at cycle 3 → each combination held 1 cycle; done at cycle 8; pass=1.

Source files
------------

// File: rtl/gate_test_pkg.sv
// -----------------------------------------------------------------------------
// gate_test_pkg
// Shared definitions for the 2-input gate self-test sequencer:
//   - state_e      : sequencer states (S_IDLE, S_APPLY, S_REPORT)
//   - TT_*         : truth tables of common gates, bit index = {a,b}
//   - COMBO_W      : width of the {a,b} combination counter
// -----------------------------------------------------------------------------
package gate_test_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_REPORT = 2'd2
    } state_e;

    localparam logic [3:0] TT_XNOR = 4'b1001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;

    localparam int unsigned COMBO_W = 2;

endpackage

// File: rtl/gate_test_sequencer_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Counts the cycles an input combination has been held. The counter wraps to
// zero on its terminal count so consecutive combinations reuse it directly.
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   clr_i  : force the count to zero (has priority over en_i)
//   en_i   : advance the count this cycle
//   tc_o   : high while the count equals DWELL_CYCLES-1
// -----------------------------------------------------------------------------
module dwell_timer #(
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gate_test_sequencer.sv
// -----------------------------------------------------------------------------
// gate_test_sequencer
// Self-test controller for a 2-input combinational gate. A start in IDLE
// sweeps {a,b} = 00,01,10,11, holding each for DWELL_CYCLES cycles and
// sampling gate_out on the last cycle of each hold. A one-cycle REPORT then
// pulses done and publishes pass/mismatch against EXPECTED.
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   start    : level, accepted only in IDLE
//   gate_out : output of the gate under test
//   gate_a   : drives gate input a
//   gate_b   : drives gate input b
//   busy     : high during APPLY and REPORT
//   done     : one-cycle pulse in REPORT
//   pass     : result == EXPECTED, held until next accepted start
//   result   : captured truth table, bit index = {a,b}
//   mismatch : result ^ EXPECTED, held until next accepted start
// -----------------------------------------------------------------------------
module gate_test_sequencer
    import gate_test_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 4,
    parameter logic [3:0]  EXPECTED     = TT_XNOR,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       gate_out,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result,
    output logic [3:0] mismatch
);

    localparam logic [COMBO_W-1:0] COMBO_LAST = '1;

    state_e             state_q;
    logic [COMBO_W-1:0] combo_q;
    logic [COMBO_W-1:0] combo_inc;
    logic               gate_a_q, gate_b_q;
    logic               busy_q, done_q, pass_q;
    logic [3:0]         result_q;
    logic [3:0]         result_d;
    logic [3:0]         mismatch_q;

    logic dwell_tc;
    logic dwell_en;
    logic dwell_clr;

    // Timer runs only while applying; it sits at zero everywhere else so the
    // first APPLY cycle always starts a fresh dwell.
    assign dwell_en  = (state_q == S_APPLY);
    assign dwell_clr = (state_q != S_APPLY);

    dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .CNT_W        (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clr_i (dwell_clr),
        .en_i  (dwell_en),
        .tc_o  (dwell_tc)
    );

    assign combo_inc = combo_q + COMBO_W'(1);

    // Result including this cycle's sample, so the final combination's bit is
    // already visible when pass/mismatch are registered on entry to REPORT.
    always_comb begin
        result_d = result_q;
        if (state_q == S_APPLY && dwell_tc) begin
            result_d[combo_q] = gate_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            combo_q    <= '0;
            gate_a_q   <= 1'b0;
            gate_b_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            result_q   <= '0;
            mismatch_q <= '0;
        end else begin
            done_q   <= 1'b0;
            result_q <= result_d;
            case (state_q)
                S_IDLE: begin
                    gate_a_q <= 1'b0;
                    gate_b_q <= 1'b0;
                    busy_q   <= 1'b0;
                    if (start) begin
                        state_q    <= S_APPLY;
                        combo_q    <= '0;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        result_q   <= '0;
                        mismatch_q <= '0;
                    end
                end
                S_APPLY: begin
                    if (dwell_tc) begin
                        if (combo_q == COMBO_LAST) begin
                            state_q    <= S_REPORT;
                            done_q     <= 1'b1;
                            gate_a_q   <= 1'b0;
                            gate_b_q   <= 1'b0;
                            pass_q     <= (result_d == EXPECTED);
                            mismatch_q <= result_d ^ EXPECTED;
                        end else begin
                            combo_q                <= combo_inc;
                            {gate_a_q, gate_b_q}   <= combo_inc;
                        end
                    end
                end
                S_REPORT: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gate_a   = gate_a_q;
    assign gate_b   = gate_b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign result   = result_q;
    assign mismatch = mismatch_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for gate_test_sequencer: two instances (dwell 4 and dwell 1) driven
// by a shared, changeable truth table standing in for the gate under test.
// A cycle-offset model predicts every output each cycle; directed sweeps pin
// the model with hand-computed literals, then a random phase follows.
// -----------------------------------------------------------------------------
module tb_gate_test_sequencer;
    import gate_test_pkg::*;

    localparam int D0 = 4;
    localparam int D1 = 1;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       busy;
        logic       done;
        logic       pass;
        logic [3:0] res;
        logic [3:0] mm;
    } obs_t;

    typedef struct {
        int   mode;   // 0 idle, 1 applying, 2 reporting
        int   k;      // apply cycles already elapsed
        obs_t o;
    } mst_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [3:0] tt;
    logic       a0, b0, busy0, done0, pass0;
    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] res0, mm0, res1, mm1;
    logic       go0, go1;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    obs_t dobs [2];
    mst_t ms   [2];

    assign go0 = tt[{a0, b0}];
    assign go1 = tt[{a1, b1}];
    assign dobs[0] = {a0, b0, busy0, done0, pass0, res0, mm0};
    assign dobs[1] = {a1, b1, busy1, done1, pass1, res1, mm1};

    gate_test_sequencer #(.DWELL_CYCLES(D0), .EXPECTED(TT_XNOR), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .gate_out(go0),
        .gate_a(a0), .gate_b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .result(res0), .mismatch(mm0)
    );

    gate_test_sequencer #(.DWELL_CYCLES(D1), .EXPECTED(TT_XNOR), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .gate_out(go1),
        .gate_a(a1), .gate_b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .result(res1), .mismatch(mm1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs after an edge, derived from how many apply cycles have elapsed:
    // combination = k / d, sample when k % d == d-1.
    function automatic mst_t model_step(input mst_t s, input int d, input logic st,
                                        input logic r, input logic [3:0] t,
                                        input logic [3:0] expv);
        mst_t n;
        int   c;
        n = s;
        n.o.done = 1'b0;
        if (r) begin
            n.mode = 0;
            n.k    = 0;
            n.o    = '0;
            return n;
        end
        case (s.mode)
            0: begin
                if (st) begin
                    n.mode   = 1;
                    n.k      = 0;
                    n.o      = '0;
                    n.o.busy = 1'b1;
                end
            end
            1: begin
                c = s.k / d;
                if (s.k % d == d - 1) n.o.res[c] = t[c];
                n.k = s.k + 1;
                if (n.k == 4 * d) begin
                    n.mode   = 2;
                    n.o.done = 1'b1;
                    n.o.a    = 1'b0;
                    n.o.b    = 1'b0;
                    n.o.pass = (n.o.res == expv);
                    n.o.mm   = n.o.res ^ expv;
                end else begin
                    n.o.a = ((n.k / d) >= 2);
                    n.o.b = ((n.k / d) % 2 == 1);
                end
            end
            default: begin
                n.mode   = 0;
                n.o.busy = 1'b0;
            end
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        ms[0] <= model_step(ms[0], D0, start0, rst, tt, TT_XNOR);
        ms[1] <= model_step(ms[1], D1, start1, rst, tt, TT_XNOR);
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dobs[i] !== ms[i].o) begin
                    errors++;
                    $display("FAIL cycle_obs dut%0d cyc=%0d got=%b want=%b (a,b,busy,done,pass,res,mm)",
                             i, cyc, dobs[i], ms[i].o);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic until_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_start(input int i, output int ts);
        ts = cyc;
        if (i == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        if (i == 0) start0 = 1'b0; else start1 = 1'b0;
    endtask

    task automatic wait_done(input int i, output int when);
        when = -1;
        for (int n = 0; n < 200; n++) begin
            if ((i == 0) ? done0 : done1) begin
                when = cyc;
                break;
            end
            @(negedge clk);
        end
        if (when < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout dut%0d cyc=%0d got=no done want=done pulse", i, cyc);
        end
    endtask

    initial begin
        int ts, td;
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        tt     = TT_XNOR;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_obs0", int'(dobs[0]), 0);
        chk("reset_obs1", int'(dobs[1]), 0);

        // XNOR gate, dwell 4, start at cycle 5
        until_cyc(5);
        pulse_start(0, ts);
        chk("busy_after_start", int'(busy0), 1);
        wait_done(0, td);
        chk("xnor_done_cycle", td, 22);
        chk("xnor_result", int'(res0), 4'b1001);
        chk("xnor_mismatch", int'(mm0), 0);
        chk("xnor_pass", int'(pass0), 1);
        repeat (3) @(negedge clk);

        // XOR gate against XNOR expectation
        tt = TT_XOR;
        pulse_start(0, ts);
        wait_done(0, td);
        chk("xor_done_cycle", td, ts + 17);
        chk("xor_result", int'(res0), 4'b0110);
        chk("xor_mismatch", int'(mm0), 4'b1111);
        chk("xor_pass", int'(pass0), 0);
        repeat (3) @(negedge clk);

        // gate_out stuck at 1
        tt = 4'b1111;
        pulse_start(0, ts);
        wait_done(0, td);
        chk("one_result", int'(res0), 4'b1111);
        chk("one_mismatch", int'(mm0), 4'b0110);
        chk("one_pass", int'(pass0), 0);
        repeat (3) @(negedge clk);

        // start re-asserted mid-sweep, then held high for back-to-back sweeps
        tt = TT_XNOR;
        pulse_start(0, ts);
        until_cyc(ts + 5);
        pulse_start(0, td);
        until_cyc(ts + 16);
        pulse_start(0, td);
        wait_done(0, td);
        chk("reassert_done_cycle", td, ts + 17);
        start0 = 1'b1;
        @(negedge clk);
        chk("b2b_idle_gap_busy", int'(busy0), 0);
        @(negedge clk);
        chk("b2b_restart_busy", int'(busy0), 1);
        start0 = 1'b0;
        wait_done(0, td);
        chk("b2b_done_cycle", td, ts + 35);
        chk("b2b_pass", int'(pass0), 1);
        repeat (3) @(negedge clk);

        // reset during combination 2
        pulse_start(0, ts);
        until_cyc(ts + 10);
        chk("pre_rst_ab", int'({a0, b0}), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_obs0", int'(dobs[0]), 0);
        until_cyc(ts + 15);
        pulse_start(0, ts);
        chk("restart_ab", int'({a0, b0}), 0);
        wait_done(0, td);
        chk("restart_done_cycle", td, ts + 17);
        chk("restart_pass", int'(pass0), 1);
        repeat (3) @(negedge clk);

        // dwell 1 instance
        pulse_start(1, ts);
        wait_done(1, td);
        chk("d1_done_cycle", td, ts + 5);
        chk("d1_result", int'(res1), 4'b1001);
        chk("d1_pass", int'(pass1), 1);
        repeat (3) @(negedge clk);

        // random phase
        for (int n = 0; n < 600; n++) begin
            start0 = ($urandom_range(3) == 0);
            start1 = ($urandom_range(3) == 0);
            rst    = ($urandom_range(59) == 0);
            if ($urandom_range(7) == 0) tt = 4'($urandom_range(15));
            @(negedge clk);
        end
        rst    = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
